// File: rtl/ones_frame_accumulator.sv
// Purpose: accumulates per-byte ones counts over FRAME_LEN-beat frames; reports sum/max/min/threshold.
// Latency: results and out_valid are visible after the edge that accepts the last beat of a frame.
// Backpressure: while a result waits for out_ready the block holds it and drops in_ready.
module ones_frame_accumulator #(
  parameter int FRAME_LEN = 8,
  parameter int SUM_W     = 8,
  parameter int THRESH    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       count_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] total,
  output logic [3:0]       max_cnt,
  output logic [3:0]       min_cnt,
  output logic             over_thresh,
  output logic [7:0]       frames_done,
  output logic             err
);

  localparam int IDX_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [31:0] THRESH_U = 32'(THRESH);

  // S_RST is the reset state so in_ready stays low until the first edge after release.
  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [SUM_W-1:0] acc;
  logic [3:0]       rmax;
  logic [3:0]       rmin;

  logic             illegal;
  logic [3:0]       c;
  logic             first;
  logic             last;
  logic             accept;
  logic             handshake;
  logic [SUM_W-1:0] acc_nxt;
  logic [3:0]       rmax_nxt;
  logic [3:0]       rmin_nxt;

  // Saturate illegal counts to 8 and fold the current beat into the running statistics.
  always_comb begin
    illegal   = (count_in > 4'd8);
    c         = illegal ? 4'd8 : count_in;
    first     = (idx == '0);
    last      = (idx == IDX_LAST);
    accept    = in_valid && in_ready && !clear;
    handshake = out_valid && out_ready && !clear;
    acc_nxt   = first ? SUM_W'(c) : acc + SUM_W'(c);
    rmax_nxt  = (first || (c > rmax)) ? c : rmax;
    rmin_nxt  = (first || (c < rmin)) ? c : rmin;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; ready/valid depend on registered state only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_RST: begin
        state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (accept && last) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_ACCUM;
        end
      end
      default: begin
        state_nxt = S_ACCUM;
      end
    endcase
    if (clear) begin
      state_nxt = S_ACCUM;
    end
  end

  // Frame accumulation, result capture on the last beat, sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx         <= '0;
      acc         <= '0;
      rmax        <= '0;
      rmin        <= '0;
      total       <= '0;
      max_cnt     <= '0;
      min_cnt     <= '0;
      over_thresh <= 1'b0;
      err         <= 1'b0;
    end else if (clear) begin
      idx  <= '0;
      acc  <= '0;
      rmax <= '0;
      rmin <= '0;
      err  <= 1'b0;
    end else if (accept) begin
      acc  <= acc_nxt;
      rmax <= rmax_nxt;
      rmin <= rmin_nxt;
      if (illegal) begin
        err <= 1'b1;
      end
      if (last) begin
        idx         <= '0;
        total       <= acc_nxt;
        max_cnt     <= rmax_nxt;
        min_cnt     <= rmin_nxt;
        over_thresh <= ({{(32 - SUM_W){1'b0}}, acc_nxt} >= THRESH_U);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Delivered-frame counter, advanced on each consumed result and wrapping at 256.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frames_done <= '0;
    end else if (handshake) begin
      frames_done <= frames_done + 8'd1;
    end
  end

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// Purpose: directed plus randomized check of ones_frame_accumulator against a frame-level model.
// Latency: outputs compared every cycle on the falling edge after each rising edge.
// Backpressure: out_ready is driven both held-low and randomly to exercise the hold state.
module tb_ones_frame_accumulator;

  localparam int FRAME_LEN = 8;
  localparam int SUM_W     = 8;
  localparam int THRESH    = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       count_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [SUM_W-1:0] total;
  logic [3:0]       max_cnt;
  logic [3:0]       min_cnt;
  logic             over_thresh;
  logic [7:0]       frames_done;
  logic             err;

  int tests = 0;
  int fails = 0;

  // Reference model: protocol state plus the beats of the frame in progress.
  bit       m_ready;
  bit       m_hold;
  bit       m_fresh;
  int       q[$];
  int       m_total, m_max, m_min;
  bit       m_over;
  bit [7:0] m_frames;
  bit       m_err;

  ones_frame_accumulator #(
    .FRAME_LEN(FRAME_LEN),
    .SUM_W(SUM_W),
    .THRESH(THRESH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .count_in(count_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .total(total),
    .max_cnt(max_cnt),
    .min_cnt(min_cnt),
    .over_thresh(over_thresh),
    .frames_done(frames_done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ready = 0; m_hold = 0; m_fresh = 1; q.delete();
    m_total = 0; m_max = 0; m_min = 0; m_over = 0; m_frames = 0; m_err = 0;
  endtask

  // One rising edge of the model, using the inputs that were presented.
  task automatic model_edge();
    bit acc, hs;
    int c, s, mx, mn;
    if (!reset) begin
      model_reset();
    end else if (clear) begin
      q.delete(); m_hold = 0; m_ready = 1; m_err = 0; m_fresh = 0;
    end else if (m_fresh) begin
      m_fresh = 0; m_ready = 1;
    end else begin
      acc = m_ready && in_valid;
      hs  = m_hold && out_ready;
      if (acc) begin
        c = (count_in > 8) ? 8 : int'(count_in);
        if (count_in > 8) m_err = 1;
        q.push_back(c);
        if (q.size() == FRAME_LEN) begin
          s = 0; mx = 0; mn = 8;
          foreach (q[i]) begin
            s += q[i];
            if (q[i] > mx) mx = q[i];
            if (q[i] < mn) mn = q[i];
          end
          m_total = s; m_max = mx; m_min = mn; m_over = (s >= THRESH);
          q.delete(); m_hold = 1; m_ready = 0;
        end
      end
      if (hs) begin
        m_hold = 0; m_ready = 1; m_frames = m_frames + 8'd1;
      end
    end
  endtask

  task automatic compare_all();
    chk("in_ready", int'(in_ready), int'(m_ready));
    chk("out_valid", int'(out_valid), int'(m_hold));
    chk("total", int'(total), m_total);
    chk("max_cnt", int'(max_cnt), m_max);
    chk("min_cnt", int'(min_cnt), m_min);
    chk("over_thresh", int'(over_thresh), int'(m_over));
    chk("frames_done", int'(frames_done), int'(m_frames));
    chk("err", int'(err), int'(m_err));
  endtask

  // Drive one cycle from the falling edge, step the model at the rising edge, compare at the next falling edge.
  task automatic cyc(input bit iv, input int cnt, input bit ordy, input bit clr, input bit rst_n);
    in_valid  = iv;
    count_in  = 4'(cnt);
    out_ready = ordy;
    clear     = clr;
    reset     = rst_n;
    if (!rst_n) model_reset();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  int nominal[8] = '{5, 8, 0, 4, 4, 3, 5, 5};

  initial begin
    model_reset();
    @(negedge clk);

    // Reset held for 3 cycles, then released.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    chk("rst_in_ready", int'(in_ready), 0);
    cyc(0, 0, 0, 0, 1);
    chk("rst_release_rdy", int'(in_ready), 1);

    // Nominal back-to-back frame with out_ready high.
    for (int i = 0; i < 8; i++) cyc(1, nominal[i], 1, 0, 1);
    chk("nom_valid", int'(out_valid), 1);
    chk("nom_total", int'(total), 34);
    chk("nom_max", int'(max_cnt), 8);
    chk("nom_min", int'(min_cnt), 0);
    chk("nom_over", int'(over_thresh), 1);
    cyc(0, 0, 1, 0, 1);
    chk("nom_pulse", int'(out_valid), 0);
    chk("nom_frames", int'(frames_done), 1);

    // Backpressure: a frame of 2s, then 5 stalled cycles with in_valid high.
    for (int i = 0; i < 8; i++) cyc(1, 2, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 2, 0, 0, 1);
      chk("bp_total", int'(total), 16);
      chk("bp_min", int'(min_cnt), 2);
      chk("bp_rdy", int'(in_ready), 0);
    end
    cyc(1, 2, 1, 0, 1);
    chk("bp_drop", int'(out_valid), 0);
    chk("bp_rdy_back", int'(in_ready), 1);
    for (int i = 0; i < 8; i++) cyc(1, 3, 1, 0, 1);
    chk("bp_frame2", int'(total), 24);
    cyc(0, 0, 1, 0, 1);

    // Gaps: counts 1..8 with in_valid alternating.
    for (int i = 0; i < 15; i++) cyc(i % 2 == 0, (i / 2) + 1, 1, 0, 1);
    chk("gap_valid", int'(out_valid), 1);
    chk("gap_total", int'(total), 36);
    chk("gap_max", int'(max_cnt), 8);
    chk("gap_min", int'(min_cnt), 1);
    cyc(0, 0, 1, 0, 1);

    // Illegal count on beat 0, sticky err, then clear mid-frame.
    cyc(1, 12, 1, 0, 1);
    chk("ill_err", int'(err), 1);
    for (int i = 0; i < 7; i++) cyc(1, 1, 1, 0, 1);
    chk("ill_max", int'(max_cnt), 8);
    for (int i = 0; i < 9; i++) cyc(1, 4, 1, 0, 1);
    chk("ill_sticky", int'(err), 1);
    for (int i = 0; i < 3; i++) cyc(1, 6, 1, 0, 1);
    cyc(1, 7, 1, 1, 1);
    chk("clr_err", int'(err), 0);
    chk("clr_valid", int'(out_valid), 0);
    for (int i = 0; i < 8; i++) cyc(1, 2, 1, 0, 1);
    chk("clr_restart", int'(total), 16);
    cyc(0, 0, 1, 0, 1);

    // Reset mid-frame.
    for (int i = 0; i < 3; i++) cyc(1, 5, 1, 0, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 1, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    chk("rmf_total", int'(total), 8);
    chk("rmf_min", int'(min_cnt), 1);
    chk("rmf_max", int'(max_cnt), 1);
    chk("rmf_frames", int'(frames_done), 1);

    // Randomized traffic, including illegal counts, clears and resets.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0,
          ($urandom_range(0, 19) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8)),
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 79) == 0,
          $urandom_range(0, 299) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
